// File: rtl/crc_channel_arbiter.sv
// Round-robin, whole-transaction arbiter sharing one CRC generator between NUM_CH channels.
// Steers the owner's message stream and out-pause into the generator and routes parity back.
module crc_channel_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int CH_BITS    = 2,
   parameter int DATA_WIDTH = 32
) (
   input  logic                         i_clk,
   input  logic                         i_RESET,
   input  logic [NUM_CH-1:0]            i_ch_request,
   input  logic [NUM_CH-1:0]            i_ch_message_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_message,
   input  logic [NUM_CH-1:0]            i_ch_out_pause,
   output logic [NUM_CH-1:0]            o_ch_grant,
   output logic [NUM_CH-1:0]            o_ch_parity_strobe,
   output logic [NUM_CH-1:0]            o_ch_parity_start,
   output logic [NUM_CH-1:0]            o_ch_done,
   output logic [DATA_WIDTH-1:0]        o_parity_out,
   output logic [CH_BITS-1:0]           o_grant_index,
   output logic                         o_execute_crc_gen,
   output logic                         o_message_valid,
   output logic [DATA_WIDTH-1:0]        o_message,
   output logic                         o_out_pause,
   input  logic                         i_crc_available,
   input  logic                         i_crc_gen_complete,
   input  logic                         i_parity_out_strobe,
   input  logic                         i_parity_out_start,
   input  logic                         i_parity_out_complete,
   input  logic [DATA_WIDTH-1:0]        i_parity_out
);
   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_RELEASE} state_t;

   localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

   state_t             r_state;
   state_t             w_next_state;
   logic [NUM_CH-1:0]  r_grant;
   logic [NUM_CH-1:0]  r_done;
   logic [CH_BITS-1:0] r_grant_index;
   logic [CH_BITS-1:0] r_last_winner;
   logic [CH_BITS-1:0] w_winner;
   logic [CH_BITS-1:0] w_cand;
   logic               w_found;
   logic               w_arbitrate;
   logic               w_busy;
   logic               r_seen_complete;

   // Search starts one past the last winner so every requester is served in turn.
   always_comb begin
      w_winner = '0;
      w_found  = 1'b0;
      w_cand   = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         w_cand = CH_BITS'((int'(r_last_winner) + k) % NUM_CH);
         if (!w_found && i_ch_request[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   assign w_arbitrate = w_found && i_crc_available;
   assign w_busy      = (r_state == S_BUSY);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (w_arbitrate) w_next_state = S_GRANT;
         S_GRANT:   w_next_state = S_BUSY;
         S_BUSY:    if (i_parity_out_complete) w_next_state = S_RELEASE;
         S_RELEASE: if (|r_done) w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_RESET) begin
         r_state         <= S_IDLE;
         r_grant         <= '0;
         r_grant_index   <= '0;
         r_last_winner   <= CH_BITS'(NUM_CH - 1);
         r_done          <= '0;
         r_seen_complete <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= '0;
         case (r_state)
            S_IDLE: begin
               r_seen_complete <= 1'b0;
               if (w_arbitrate) begin
                  r_grant       <= ONE_HOT0 << w_winner;
                  r_grant_index <= w_winner;
               end
            end
            S_BUSY: begin
               if (i_crc_gen_complete) r_seen_complete <= 1'b1;
            end
            S_RELEASE: begin
               // Done is a registered pulse; ownership is dropped on the edge after it.
               if (|r_done) begin
                  r_grant       <= '0;
                  r_grant_index <= '0;
               end else if (i_crc_available) begin
                  r_done        <= r_grant;
                  r_last_winner <= r_grant_index;
               end
            end
            default: ;
         endcase
      end
   end

   // A legal generator reports crc_gen_complete before parity completes; release does not wait on it.
   always_ff @(posedge i_clk) begin
      if (!i_RESET && w_busy && i_parity_out_complete)
         assert (r_seen_complete || i_crc_gen_complete);
   end

   always_comb begin
      o_message_valid    = 1'b0;
      o_message          = '0;
      o_out_pause        = 1'b0;
      o_ch_parity_strobe = '0;
      o_ch_parity_start  = '0;
      o_parity_out       = '0;
      if (w_busy) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (r_grant[k]) begin
               o_message_valid = i_ch_message_valid[k];
               o_message       = i_ch_message[k*DATA_WIDTH +: DATA_WIDTH];
               o_out_pause     = i_ch_out_pause[k];
            end
         end
         o_ch_parity_strobe = r_grant & {NUM_CH{i_parity_out_strobe}};
         o_ch_parity_start  = r_grant & {NUM_CH{i_parity_out_start}};
         if (i_parity_out_strobe) o_parity_out = i_parity_out;
      end
   end

   assign o_ch_grant        = r_grant;
   assign o_grant_index     = r_grant_index;
   assign o_ch_done         = r_done;
   assign o_execute_crc_gen = w_busy;

endmodule

// File: tb/tb_crc_channel_arbiter.sv
// Self-checking bench for crc_channel_arbiter: cycle table, directed transactions, and
// randomized traffic compared against a transaction-level ownership model.
module tb_crc_channel_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req, mvalid, pause;
   logic [N*DW-1:0] msgs;
   logic            avail, gcomp, pstb, pstart, pcomp;
   logic [DW-1:0]   pin;

   logic [N-1:0]    grant, stb, start, done;
   logic [DW-1:0]   par, msg;
   logic [1:0]      gidx;
   logic            exec, mv, opause;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the generator and where the transaction is.
   int m_owner = -1;
   int m_last  = N - 1;
   int m_age   = 0;
   bit m_completed = 1'b0;
   bit m_done = 1'b0;

   always #5 clk = ~clk;

   crc_channel_arbiter #(.NUM_CH(N), .CH_BITS(2), .DATA_WIDTH(DW)) dut (
      .i_clk(clk), .i_RESET(rst),
      .i_ch_request(req), .i_ch_message_valid(mvalid), .i_ch_message(msgs), .i_ch_out_pause(pause),
      .o_ch_grant(grant), .o_ch_parity_strobe(stb), .o_ch_parity_start(start), .o_ch_done(done),
      .o_parity_out(par), .o_grant_index(gidx), .o_execute_crc_gen(exec), .o_message_valid(mv),
      .o_message(msg), .o_out_pause(opause),
      .i_crc_available(avail), .i_crc_gen_complete(gcomp), .i_parity_out_strobe(pstb),
      .i_parity_out_start(pstart), .i_parity_out_complete(pcomp), .i_parity_out(pin)
   );

   typedef struct {
      logic [3:0]  req;
      logic        avail, gcomp, pstb, pstart, pcomp;
      logic [31:0] pin;
      logic [3:0]  e_grant;
      logic [1:0]  e_idx;
      logic        e_exec;
      logic [3:0]  e_done, e_stb, e_start;
      logic [31:0] e_par;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] dut_vec();
      return {43'd0, grant, gidx, exec, mv, msg, opause, stb, start, done, par};
   endfunction

   function automatic logic [127:0] model_vec();
      logic [N-1:0] oh;
      logic         ex;
      int           o;
      o  = (m_owner >= 0) ? m_owner : 0;
      oh = (m_owner >= 0) ? (4'b0001 << o) : 4'b0000;
      ex = (m_owner >= 0) && (m_age >= 1) && !m_completed;
      return {43'd0, oh, 2'(o), ex, ex & mvalid[o], ex ? msgs[o*DW +: DW] : 32'd0, ex & pause[o],
              (ex && pstb) ? oh : 4'b0000, (ex && pstart) ? oh : 4'b0000,
              m_done ? oh : 4'b0000, (ex && pstb) ? pin : 32'd0};
   endfunction

   // Advance the model by one rising edge using the inputs about to be sampled.
   task automatic model_step();
      bit found;
      if (rst) begin
         m_owner = -1; m_last = N - 1; m_age = 0; m_completed = 1'b0; m_done = 1'b0;
      end else if (m_owner < 0) begin
         if (req != 0 && avail) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               if (!found && req[(m_last + k) % N]) begin
                  found = 1'b1;
                  m_owner = (m_last + k) % N;
               end
            end
            m_age = 0;
            m_completed = 1'b0;
         end
      end else if (m_done) begin
         m_last = m_owner; m_owner = -1; m_done = 1'b0;
      end else if (m_completed) begin
         if (avail) m_done = 1'b1;
      end else begin
         if (m_age >= 1 && pcomp) m_completed = 1'b1;
         m_age++;
      end
   endtask

   task automatic tick();
      #1;
      chk("model", dut_vec(), model_vec());
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mvalid = '0; msgs = '0; pause = '0; gcomp = 1'b0;
      pstb = 1'b0; pstart = 1'b0; pcomp = 1'b0; pin = '0;
   endtask

   // One full transaction for channel ch, driven as a legal generator would.
   task automatic transaction(input int ch, input int nwords, input bit drop_req,
                              input int pause_len, input int avail_low);
      logic [N-1:0] mask;
      int n, sent, stb_cnt, start_cnt, done_cnt;
      mask = 4'b0001 << ch;
      stb_cnt = 0; start_cnt = 0; done_cnt = 0;
      n = 0;
      while (exec !== 1'b1 && n < 20) begin tick(); n++; end
      chk("exec within bound", 128'(exec), 128'd1);
      chk($sformatf("grant ch%0d", ch), 128'(grant), 128'(mask));
      chk($sformatf("grant index ch%0d", ch), 128'(gidx), 128'(ch));
      sent = 0;
      while (sent < nwords) begin
         mvalid = 4'($urandom);
         msgs = {$urandom, $urandom, $urandom, $urandom};
         if (drop_req && sent >= nwords / 2) req[ch] = 1'b0;
         if (mvalid[ch]) sent++;
         tick();
      end
      mvalid = '0; msgs = '0;
      chk("grant held through stream", 128'(grant), 128'(mask));
      gcomp = 1'b1; tick(); gcomp = 1'b0;
      pstb = 1'b1; pstart = 1'b1; pin = $urandom;
      #1;
      if (stb == mask) stb_cnt++;
      if (start == mask) start_cnt++;
      tick();
      pstb = 1'b0; pstart = 1'b0;
      for (int p = 0; p < pause_len; p++) begin
         pause[ch] = 1'b1;
         if (ch != 3) pause[3] = ~pause[3];
         #1;
         chk("out_pause mirrors owner", 128'(opause), 128'd1);
         tick();
      end
      pause = '0;
      pstb = 1'b1; pcomp = 1'b1; pin = $urandom;
      #1;
      if (stb == mask) stb_cnt++;
      if (start == mask) start_cnt++;
      tick();
      pstb = 1'b0; pcomp = 1'b0; pin = '0;
      avail = 1'b0;
      for (int a = 0; a < avail_low; a++) begin
         #1;
         chk("held in release", 128'({grant, done, exec}), 128'({mask, 4'b0000, 1'b0}));
         tick();
      end
      avail = 1'b1;
      n = 0;
      while (done_cnt == 0 && n < 6) begin
         #1;
         if (done == mask) done_cnt++;
         tick();
         n++;
      end
      chk("done pulse", 128'(done_cnt), 128'd1);
      #1;
      chk("released", 128'({grant, done}), 128'd0);
      chk("parity strobes", 128'(stb_cnt), 128'd2);
      chk("parity start", 128'(start_cnt), 128'd1);
   endtask

   initial begin
      // req avail gcomp pstb pstart pcomp pin | grant idx exec done stb start par
      tbl[0]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0};
      tbl[1]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0100, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0};
      tbl[2]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0};
      tbl[3]  = '{4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0};
      tbl[4]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA5A5, 4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0100, 4'b0100, 32'hA5A5};
      tbl[5]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h5A5A, 4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0100, 4'b0000, 32'h5A5A};
      tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF, 4'b0100, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0};
      tbl[7]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0100, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0};
      tbl[8]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0100, 2'd2, 1'b0, 4'b0100, 4'b0000, 4'b0000, 32'h0};
      tbl[9]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0};
      tbl[10] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0001, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0};
      tbl[11] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0};

      rst = 1'b1; req = '0; avail = 1'b1;
      idle_inputs();
      model_step(); @(posedge clk); #1;
      model_step(); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("reset outputs", dut_vec(), 128'd0);

      for (int i = 0; i < 12; i++) begin
         req = tbl[i].req; avail = tbl[i].avail; gcomp = tbl[i].gcomp;
         pstb = tbl[i].pstb; pstart = tbl[i].pstart; pcomp = tbl[i].pcomp; pin = tbl[i].pin;
         #1;
         chk($sformatf("table row %0d", i), 128'({grant, gidx, exec, done, stb, start, par}),
             128'({tbl[i].e_grant, tbl[i].e_idx, tbl[i].e_exec, tbl[i].e_done,
                   tbl[i].e_stb, tbl[i].e_start, tbl[i].e_par}));
         tick();
      end

      // Channel 0 is now two cycles into BUSY.
      idle_inputs(); req = '0; rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("reset mid-busy", dut_vec(), 128'd0);

      req = 4'b1111;
      transaction(0, 3, 1'b0, 0, 0);
      transaction(1, 3, 1'b0, 0, 0);
      transaction(2, 3, 1'b0, 0, 0);
      transaction(3, 3, 1'b0, 0, 0);
      transaction(0, 3, 1'b0, 0, 0);

      req = 4'b0100;
      transaction(2, 4158, 1'b0, 0, 0);

      req = 4'b0010;
      transaction(1, 3, 1'b0, 5, 0);

      req = 4'b0001;
      transaction(0, 6, 1'b1, 0, 0);

      req = 4'b1100;
      transaction(2, 3, 1'b0, 0, 10);

      idle_inputs(); req = '0; rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 7) == 0) req = 4'($urandom);
         mvalid = 4'($urandom);
         msgs = {$urandom, $urandom, $urandom, $urandom};
         pause = 4'($urandom);
         avail = ($urandom_range(0, 3) != 0);
         pstb = ($urandom_range(0, 2) == 0);
         pstart = pstb && ($urandom_range(0, 3) == 0);
         pin = $urandom;
         pcomp = ($urandom_range(0, 9) == 0);
         gcomp = pcomp || ($urandom_range(0, 9) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit after %0d checks", checks);
      $fatal(1, "watchdog");
   end
endmodule
